framebuffer_dbuf: RTL and testbench
===================================

// Module: framebuffer_dbuf
// PURPOSE
//  Double-buffered pixel framebuffer between the HPS/Avalon pixel writer and the HDMI scan-out.
//  Two pages live in an inferred true-dual-port RAM.
//  The HDMI side always reads the front page; the HPS side writes the back page.
//  Pages swap only at a frame boundary, so scan-out never tears.
//  Generalised in resolution and pixel width; adds a write handshake, bounds checking and an optional hardware clear.
// PARAMETERS
//  PIX_W    8    bits per pixel
//  H_RES    640  pixels per line (x range 0..H_RES-1)
//  V_RES    480  lines per frame (y range 0..V_RES-1)
//  COORD_W  10   width of the x and y coordinate ports; must satisfy 2**COORD_W >= max(H_RES,V_RES)
//  Derived: PAGE = H_RES*V_RES; ADDR_W = $clog2(2*PAGE)
// PORTS
//  clk          in   1        system clock; all logic rising-edge
//  rst          in   1        synchronous reset, active high
//  rd_en        in   1        HDMI read strobe
//  rd_x, rd_y   in   COORD_W  HDMI pixel coordinate
//  rd_data      out  PIX_W    front-page pixel
//  rd_valid     out  1        rd_data valid
//  wr_valid     in   1        HPS write request
//  wr_ready     out  1        write accepted when wr_valid & wr_ready
//  wr_x, wr_y   in   COORD_W  HPS pixel coordinate
//  wr_data      in   PIX_W    pixel to write
//  swap_req     in   1        pulse: request page swap
//  frame_start  in   1        one-cycle pulse from HDMI timing at start of vertical blank
//  swap_pending out  1        swap requested, not yet executed
//  swap_done    out  1        one-cycle pulse when pages swap
//  front_sel    out  1        page currently scanned out
//  wr_err       out  1        sticky: an out-of-range write was dropped
//  err_clr      in   1        clears wr_err
//  clr_start    in   1        start back-page clear (FB_CLEAR_EN)
//  clr_color    in   PIX_W    clear value (FB_CLEAR_EN)
//  clr_busy     out  1        clear in progress
// BEHAVIOUR
//  Reset values: front_sel=0, rd_valid=0, rd_data=0, swap_pending=0, swap_done=0, wr_err=0, clr_busy=0, wr_ready=0.
//  Write FSM enters IDLE after reset. RAM contents are not cleared by reset.
//  Reset mid-operation aborts any clear and any pending swap.
//  Addressing: addr = page*PAGE + y*H_RES + x. Arithmetic is unsigned and computed at ADDR_W width; no truncation.
//  Read path, fixed latency 2:
//   - cycle 0: rd_en sampled and address registered.
//   - cycle 2: rd_data and rd_valid=1 presented. rd_valid follows rd_en delayed by 2 cycles.
//   - Out-of-range read (x>=H_RES or y>=V_RES): rd_data=0 with rd_valid=1.
//   - Page is sampled at cycle 0. A swap in cycle 1 does not affect that read.
//  Write FSM states IDLE, CLEAR, SWAP_WAIT:
//   - IDLE: wr_ready=1. On handshake, RAM write of back page (~front_sel) commits on the next edge.
//   - Out-of-range write: handshake completes, no RAM write, wr_err<=1.
//   - err_clr and a new error in the same cycle: wr_err=1 (set wins).
//   - IDLE -> SWAP_WAIT on swap_req; swap_pending=1; wr_ready=0.
//   - IDLE -> CLEAR on clr_start (FB_CLEAR_EN only).
//   - swap_req and clr_start in the same cycle: clr_start wins; swap_req is latched as pending and taken after the clear.
//   - SWAP_WAIT: on frame_start, front_sel toggles, swap_done pulses, swap_pending=0, return to IDLE.
//   - swap_req coincident with frame_start while in IDLE: the swap executes at that same edge.
//   - swap_req while already pending is ignored.
//   - CLEAR: writes clr_color to back page addresses 0..PAGE-1, one per cycle, PAGE cycles.
//     clr_busy=1 and wr_ready=0 throughout. clr_start is ignored while busy.
//     On the last address, go to SWAP_WAIT if a swap is pending, else IDLE.
//  Back-page writes never alias the front page, so there is no read/write collision on the same address.
// CONFIGURATION
//  FB_CLEAR_EN defined: CLEAR state, clear counter and clr_* behaviour as above.
//  FB_CLEAR_EN undefined: clr_* ports are present; clr_start and clr_color are ignored; clr_busy is tied 0; CLEAR state is absent.
// TESTING
//  T1 Reset, then write (x=5,y=0)=0xA5. Back-page RAM at addr PAGE+5 = 0xA5. A front-page read of (5,0) returns the old value 2 cycles later.
//  T2 swap_req; hold wr_valid: wr_ready=0. Pulse frame_start: swap_done=1, front_sel=1. A read of (5,0) returns 0xA5 with latency 2.
//  T3 Write (640,10) at H_RES=640: handshake completes, no RAM change, wr_err=1. err_clr: wr_err=0. Read (639,479) ok; read (700,0) returns 0, rd_valid=1.
//  T4 swap_req coincident with frame_start in IDLE: swap on that edge. A second swap_req while pending produces only one toggle.
//  T5 (FB_CLEAR_EN) clr_start with clr_color=0x3C and a swap_req 10 cycles later:
//     clr_busy is high for exactly PAGE cycles; all back-page words = 0x3C; swap occurs at the first frame_start after the clear.
//  T6 Assert rst during CLEAR and during SWAP_WAIT: all outputs return to their reset values next cycle; front_sel=0.

Source files
------------

// File: rtl/framebuffer_dbuf.sv
// Double-buffered pixel framebuffer: two pages in one dual-port RAM, HDMI reads the front page,
// HPS writes the back page, pages swap only on frame_start. Define FB_CLEAR_EN for hardware back-page clear.
module framebuffer_dbuf #(
   parameter int PIX_W   = 8,
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int COORD_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic [COORD_W-1:0] rd_x,
   input  logic [COORD_W-1:0] rd_y,
   output logic [PIX_W-1:0]   rd_data,
   output logic               rd_valid,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [COORD_W-1:0] wr_x,
   input  logic [COORD_W-1:0] wr_y,
   input  logic [PIX_W-1:0]   wr_data,
   input  logic               swap_req,
   input  logic               frame_start,
   output logic               swap_pending,
   output logic               swap_done,
   output logic               front_sel,
   output logic               wr_err,
   input  logic               err_clr,
   input  logic               clr_start,
   input  logic [PIX_W-1:0]   clr_color,
   output logic               clr_busy
);
   localparam int PAGE   = H_RES * V_RES;
   localparam int ADDR_W = $clog2(2 * PAGE);
   localparam int RD_LAT = 2;
   localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
   localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

`ifdef FB_CLEAR_EN
   typedef enum logic [1:0] {IDLE, SWAP_WAIT, CLEAR} state_t;
`else
   typedef enum logic [0:0] {IDLE, SWAP_WAIT} state_t;
`endif

   function automatic logic [ADDR_W-1:0] page_base(input logic page);
      return page ? ADDR_W'(PAGE) : '0;
   endfunction

   function automatic logic [ADDR_W-1:0] pix_addr(input logic page,
                                                   input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
      logic [ADDR_W-1:0] xa;
      logic [ADDR_W-1:0] ya;
      xa = ADDR_W'(x);
      ya = ADDR_W'(y);
      return page_base(page) + ya * ADDR_W'(H_RES) + xa;
   endfunction

   state_t            state_reg, state_next;
   logic              front_sel_reg, front_sel_next;
   logic              pend_reg, pend_next;
   logic              done_reg, done_next;
   logic              ready_reg, ready_next;
   logic              err_reg, err_next, err_set;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [PIX_W-1:0]  ram_wdata;
   logic              wr_oob, rd_oob, wr_hs;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr_reg;
   logic [PIX_W-1:0]  ram_q_reg;
   logic [RD_LAT-1:0] rd_vld_reg, rd_oob_reg;

   logic [PIX_W-1:0]  mem [0:2*PAGE-1];

   assign wr_oob  = ({1'b0, wr_x} >= H_LIM) || ({1'b0, wr_y} >= V_LIM);
   assign rd_oob  = ({1'b0, rd_x} >= H_LIM) || ({1'b0, rd_y} >= V_LIM);
   assign wr_addr = pix_addr(~front_sel_reg, wr_x, wr_y);
   assign wr_hs   = wr_valid & ready_reg;

   // Read path: page and address captured at the rd_en edge, RAM output registered one edge later.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_reg <= '0;
         rd_oob_reg <= '0;
      end else begin
         rd_vld_reg <= {rd_vld_reg[RD_LAT-2:0], rd_en};
         rd_oob_reg <= {rd_oob_reg[RD_LAT-2:0], rd_oob};
      end
   end

   always_ff @(posedge clk) begin
      rd_addr_reg <= rd_oob ? '0 : pix_addr(front_sel_reg, rd_x, rd_y);
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
   end

   always_ff @(posedge clk) begin
      ram_q_reg <= mem[rd_addr_reg];
   end

   assign rd_valid = rd_vld_reg[RD_LAT-1];
   assign rd_data  = (rd_valid && !rd_oob_reg[RD_LAT-1]) ? ram_q_reg : '0;

`ifdef FB_CLEAR_EN
   logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
   logic              clr_last;

   assign clr_last = (clr_cnt_reg == ADDR_W'(PAGE - 1));
   assign clr_busy = (state_reg == CLEAR);

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt_reg <= '0;
      end else begin
         clr_cnt_reg <= clr_cnt_next;
      end
   end
`else
   logic unused_clr;
   assign unused_clr = ^{clr_start, clr_color};
   assign clr_busy   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         front_sel_reg <= 1'b0;
         pend_reg      <= 1'b0;
         done_reg      <= 1'b0;
         ready_reg     <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         front_sel_reg <= front_sel_next;
         pend_reg      <= pend_next;
         done_reg      <= done_next;
         ready_reg     <= ready_next;
         err_reg       <= err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      front_sel_next = front_sel_reg;
      pend_next      = pend_reg;
      done_next      = 1'b0;
      ready_next     = 1'b0;
      err_set        = 1'b0;
      ram_we         = 1'b0;
      ram_waddr      = wr_addr;
      ram_wdata      = wr_data;
`ifdef FB_CLEAR_EN
      clr_cnt_next   = clr_cnt_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (wr_hs) begin
               if (wr_oob) begin
                  err_set = 1'b1;
               end else begin
                  ram_we = 1'b1;
               end
            end
`ifdef FB_CLEAR_EN
            // A coincident swap request is remembered and honoured once the clear finishes.
            if (clr_start) begin
               state_next   = CLEAR;
               clr_cnt_next = '0;
               pend_next    = swap_req;
            end else
`endif
            if (swap_req && frame_start) begin
               front_sel_next = ~front_sel_reg;
               done_next      = 1'b1;
            end else if (swap_req) begin
               state_next = SWAP_WAIT;
            end
         end
         SWAP_WAIT: begin
            if (frame_start) begin
               front_sel_next = ~front_sel_reg;
               done_next      = 1'b1;
               state_next     = IDLE;
            end
         end
`ifdef FB_CLEAR_EN
         CLEAR: begin
            ram_we       = 1'b1;
            ram_waddr    = page_base(~front_sel_reg) + clr_cnt_reg;
            ram_wdata    = clr_color;
            clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
            if (swap_req) begin
               pend_next = 1'b1;
            end
            if (clr_last) begin
               state_next = (pend_reg || swap_req) ? SWAP_WAIT : IDLE;
               pend_next  = 1'b0;
            end
         end
`endif
         default: begin
            state_next = IDLE;
         end
      endcase
      ready_next = (state_next == IDLE);
      err_next   = err_set | (err_reg & ~err_clr);
   end

   assign wr_ready     = ready_reg;
   assign swap_done    = done_reg;
   assign front_sel    = front_sel_reg;
   assign wr_err       = err_reg;
   assign swap_pending = (state_reg == SWAP_WAIT) | pend_reg;

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Scoreboard bench for framebuffer_dbuf on a small frame; reads and swaps are checked by monitors
// against a whole-frame array model of both pages.
module tb_framebuffer_dbuf;
   localparam int PIX_W   = 8;
   localparam int H_RES   = 16;
   localparam int V_RES   = 12;
   localparam int COORD_W = 6;
   localparam int PAGE    = H_RES * V_RES;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               rd_en = 1'b0;
   logic [COORD_W-1:0] rd_x = '0;
   logic [COORD_W-1:0] rd_y = '0;
   logic [PIX_W-1:0]   rd_data;
   logic               rd_valid;
   logic               wr_valid = 1'b0;
   logic               wr_ready;
   logic [COORD_W-1:0] wr_x = '0;
   logic [COORD_W-1:0] wr_y = '0;
   logic [PIX_W-1:0]   wr_data = '0;
   logic               swap_req = 1'b0;
   logic               frame_start = 1'b0;
   logic               swap_pending;
   logic               swap_done;
   logic               front_sel;
   logic               wr_err;
   logic               err_clr = 1'b0;
   logic               clr_start = 1'b0;
   logic [PIX_W-1:0]   clr_color = '0;
   logic               clr_busy;

   framebuffer_dbuf #(
      .PIX_W(PIX_W), .H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
      .swap_req(swap_req), .frame_start(frame_start), .swap_pending(swap_pending),
      .swap_done(swap_done), .front_sel(front_sel), .wr_err(wr_err), .err_clr(err_clr),
      .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: both pages as one flat array, plus the architectural flags.
   logic [PIX_W-1:0] mem_m [2*PAGE];
   bit front_m = 1'b0;
   bit err_m   = 1'b0;

   typedef struct { int due; logic [PIX_W-1:0] data; } rd_exp_t;
   typedef struct { int due; bit front; } sw_exp_t;
   rd_exp_t rd_q[$];
   sw_exp_t sw_q[$];
   rd_exp_t rd_e;
   sw_exp_t sw_e;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic bit in_rng(input int x, input int y);
      return (x < H_RES) && (y < V_RES);
   endfunction

   function automatic int maddr(input bit pg, input int x, input int y);
      return int'(pg) * PAGE + y * H_RES + x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitors: pop an expectation whenever the DUT presents a read or a swap.
   always @(negedge clk) begin
      if (rd_valid) begin
         if (rd_q.size() == 0) begin
            chk("rd_unexpected", 1, 0);
         end else begin
            rd_e = rd_q.pop_front();
            chk("rd_latency", cyc, rd_e.due);
            chk("rd_data", int'(rd_data), int'(rd_e.data));
            $display("read   cycle %0d data %02h expected %02h", cyc, rd_data, rd_e.data);
         end
      end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
         rd_e = rd_q.pop_front();
         chk("rd_missing", 0, 1);
      end
      if (swap_done) begin
         if (sw_q.size() == 0) begin
            chk("swap_unexpected", 1, 0);
         end else begin
            sw_e = sw_q.pop_front();
            chk("swap_cycle", cyc, sw_e.due);
            chk("swap_front", int'(front_sel), int'(sw_e.front));
            $display("swap   cycle %0d front_sel %0d", cyc, front_sel);
         end
      end else if (sw_q.size() != 0 && sw_q[0].due <= cyc) begin
         sw_e = sw_q.pop_front();
         chk("swap_missing", 0, 1);
      end
   end

   task automatic set_read(input int x, input int y);
      rd_exp_t e;
      rd_en = 1'b1;
      rd_x  = COORD_W'(x);
      rd_y  = COORD_W'(y);
      e.due  = cyc + 2;
      e.data = in_rng(x, y) ? mem_m[maddr(front_m, x, y)] : '0;
      rd_q.push_back(e);
   endtask

   task automatic issue_read(input int x, input int y);
      set_read(x, y);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic do_write(input int x, input int y, input logic [PIX_W-1:0] d, input bit clr);
      int guard = 0;
      wr_valid = 1'b1;
      wr_x = COORD_W'(x);
      wr_y = COORD_W'(y);
      wr_data = d;
      err_clr = clr;
      @(negedge clk);
      while (!wr_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!wr_ready) chk("wr_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      err_clr  = 1'b0;
      if (in_rng(x, y)) mem_m[maddr(!front_m, x, y)] = d;
      else err_m = 1'b1;
      if (clr && in_rng(x, y)) err_m = 1'b0;
      chk("wr_err", int'(wr_err), int'(err_m));
      $display("write  cycle %0d (%0d,%0d)=%02h wr_err %0d", cyc, x, y, d, wr_err);
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      err_m = 1'b0;
      chk("err_clr", int'(wr_err), 0);
   endtask

   task automatic swap_coincident();
      sw_exp_t s;
      swap_req = 1'b1;
      frame_start = 1'b1;
      s.due = cyc + 1;
      s.front = !front_m;
      sw_q.push_back(s);
      tick();
      swap_req = 1'b0;
      frame_start = 1'b0;
      front_m = !front_m;
      chk("coinc_front", int'(front_sel), int'(front_m));
      chk("coinc_pending", int'(swap_pending), 0);
      chk("coinc_ready", int'(wr_ready), 1);
      tick();
   endtask

   // Deferred swap; wr_valid is held while waiting and must not be accepted.
   task automatic do_swap(input int waits, input bit dup, input bit rd);
      sw_exp_t s;
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      chk("swap_pending", int'(swap_pending), 1);
      chk("ready_in_wait", int'(wr_ready), 0);
      wr_valid = 1'b1;
      wr_x = COORD_W'($urandom_range(0, H_RES-1));
      wr_y = COORD_W'($urandom_range(0, V_RES-1));
      wr_data = PIX_W'($urandom);
      for (int i = 0; i < waits; i++) begin
         if (dup && i == 0) swap_req = 1'b1;
         if (rd && i == waits - 1) set_read($urandom_range(0, H_RES-1), $urandom_range(0, V_RES-1));
         tick();
         swap_req = 1'b0;
         rd_en = 1'b0;
      end
      wr_valid = 1'b0;
      frame_start = 1'b1;
      if (rd) set_read($urandom_range(0, H_RES-1), $urandom_range(0, V_RES-1));
      s.due = cyc + 1;
      s.front = !front_m;
      sw_q.push_back(s);
      tick();
      frame_start = 1'b0;
      rd_en = 1'b0;
      front_m = !front_m;
      chk("swap_pending_clr", int'(swap_pending), 0);
      chk("front_sel", int'(front_sel), int'(front_m));
      if (rd) issue_read($urandom_range(0, H_RES-1), $urandom_range(0, V_RES-1));
      tick();
   endtask

   task automatic reset_mid();
      rst = 1'b1;
      tick();
      chk("rst_front_sel", int'(front_sel), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_swap_pending", int'(swap_pending), 0);
      chk("rst_swap_done", int'(swap_done), 0);
      chk("rst_wr_err", int'(wr_err), 0);
      chk("rst_clr_busy", int'(clr_busy), 0);
      chk("rst_wr_ready", int'(wr_ready), 0);
      rst = 1'b0;
      front_m = 1'b0;
      err_m = 1'b0;
      tick();
   endtask

   task automatic fill_back_page();
      for (int a = 0; a < PAGE; a++) do_write(a % H_RES, a / H_RES, PIX_W'($urandom), 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int x, y, op, n;
      tick();
      tick();
      reset_mid();
      rst = 1'b0;

      // Establish known contents in both pages.
      fill_back_page();
      swap_coincident();
      fill_back_page();
      swap_coincident();

      // Back-page write leaves the front page untouched; after the swap it becomes visible.
      do_write(5, 0, 8'hA5, 1'b0);
      issue_read(5, 0);
      do_swap(3, 1'b1, 1'b1);
      issue_read(5, 0);

      // Out-of-range writes and reads; set wins over a simultaneous clear.
      do_write(H_RES, 10, 8'h77, 1'b0);
      pulse_err_clr();
      issue_read(H_RES-1, V_RES-1);
      issue_read(63, 0);
      issue_read(0, V_RES);
      do_write(H_RES, 0, 8'h11, 1'b1);
      pulse_err_clr();

      swap_coincident();
      do_swap(2, 1'b1, 1'b0);

`ifndef FB_CLEAR_EN
      clr_start = 1'b1;
      clr_color = 8'h3C;
      tick();
      clr_start = 1'b0;
      chk("clr_ignored_busy", int'(clr_busy), 0);
      chk("clr_ignored_ready", int'(wr_ready), 1);
`endif

      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 9);
         if (op <= 3) begin
            x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, H_RES-1);
            y = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, V_RES-1);
            do_write(x, y, PIX_W'($urandom), ($urandom_range(0, 3) == 0));
         end else if (op <= 6) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
               x = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, H_RES-1);
               y = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, V_RES-1);
               set_read(x, y);
               tick();
            end
            rd_en = 1'b0;
         end else if (op == 7) begin
            do_swap($urandom_range(1, 4), $urandom_range(0, 1), 1'b1);
         end else if (op == 8) begin
            swap_coincident();
         end else begin
            pulse_err_clr();
         end
      end

      // Reset while a swap is pending.
      tick();
      tick();
      tick();
      do_write(63, 63, 8'h00, 1'b0);
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      chk("pend_before_rst", int'(swap_pending), 1);
      reset_mid();
      for (int k = 0; k < 6; k++) issue_read($urandom_range(0, H_RES-1), $urandom_range(0, V_RES-1));

`ifdef FB_CLEAR_EN
      // Reset part-way through a clear of page 1; then restore the first line it may have touched.
      tick();
      tick();
      clr_start = 1'b1;
      clr_color = 8'hEE;
      tick();
      clr_start = 1'b0;
      chk("clr_busy_start", int'(clr_busy), 1);
      tick();
      tick();
      reset_mid();
      for (int k = 0; k < H_RES; k++) do_write(k, 0, PIX_W'($urandom), 1'b0);

      // Full clear with a swap request arriving mid-clear.
      begin
         int busy = 0;
         bit f;
         sw_exp_t s;
         f = front_m;
         clr_start = 1'b1;
         clr_color = 8'h3C;
         tick();
         clr_start = 1'b0;
         chk("clr_ready_low", int'(wr_ready), 0);
         for (int a = 0; a < PAGE; a++) mem_m[maddr(!f, 0, 0) + a] = 8'h3C;
         while (clr_busy && busy < PAGE + 50) begin
            busy++;
            if (busy == 10) swap_req = 1'b1;
            if (busy == 20) clr_start = 1'b1;
            if (busy == 50) frame_start = 1'b1;
            tick();
            swap_req = 1'b0;
            clr_start = 1'b0;
            frame_start = 1'b0;
         end
         chk("clr_busy_cycles", busy, PAGE);
         chk("clr_then_pending", int'(swap_pending), 1);
         chk("clr_no_early_swap", int'(front_sel), int'(f));
         tick();
         frame_start = 1'b1;
         s.due = cyc + 1;
         s.front = !f;
         sw_q.push_back(s);
         tick();
         frame_start = 1'b0;
         front_m = !f;
         chk("clr_swap_front", int'(front_sel), int'(front_m));
         for (int k = 0; k < 8; k++) issue_read($urandom_range(0, H_RES-1), $urandom_range(0, V_RES-1));
      end
`endif

      for (int k = 0; k < 5; k++) tick();
      chk("rd_queue_drained", rd_q.size(), 0);
      chk("swap_queue_drained", sw_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
